// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// The stage's 2-entry {pc, instruction} buffer uses the count helper below.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_WORD_W   = 16;
    localparam int DEF_RESET_PC = 0;
    localparam int FETCH_DEPTH  = 2;
    localparam int CNT_W        = 2;

    typedef logic [CNT_W-1:0] fifo_cnt_t;

    function automatic fifo_cnt_t cnt_next(input fifo_cnt_t cnt, input logic push, input logic pop);
        fifo_cnt_t nxt;
        case ({push, pop})
            2'b10:   nxt = cnt + 2'd1;
            2'b01:   nxt = cnt - 2'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_skid_fifo.sv
// Two-entry buffer of fetched {pc, instruction} pairs.
// A flush empties it and takes priority over push and pop.
module fetch_skid_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    fifo_cnt_t         count_r;
    logic              pop_ok_s;
    logic              push_ok_s;

    // Qualify requests against the occupancy; a full buffer accepts a push only alongside a pop.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop & (count_r != 2'd0);
            push_ok_s = push & ((count_r < 2'(FETCH_DEPTH)) | pop_ok_s);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            wr_ptr_r <= wr_ptr_r ^ push_ok_s;
            rd_ptr_r <= rd_ptr_r ^ pop_ok_s;
            count_r  <= cnt_next(count_r, push_ok_s, pop_ok_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory address from the PC register and
// queues fetched words for decode, with redirect and halt control.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_r;
    logic [1:0]        count_s;
    logic              pop_s;
    logic              fetch_s;

    // Redirect suppresses fetch; a full buffer may still fetch when the head leaves.
    always_comb begin
        pop_s   = inst_valid & inst_ready;
        fetch_s = 1'b0;
        if (halt || redirect_valid) begin
            fetch_s = 1'b0;
        end else begin
            fetch_s = (count_s < 2'(FETCH_DEPTH)) | pop_s;
        end
    end

    // PC register; the increment wraps naturally at the top of the address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RST_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc;
        end else if (fetch_s) begin
            pc_r <= pc_r + ADDR_W'(1);
        end
    end

    fetch_skid_fifo #(
        .DATA_W (ADDR_W + WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .push_data ({pc_r, mem_rdata}),
        .count     (count_s),
        .head      ({inst_pc, inst_data})
    );

    assign mem_addr   = pc_r;
    assign inst_valid = (count_s != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural memory where word[i] = i ^ 16'hA5A5.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        halt;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [9:0]  inst_pc;

    logic [15:0] mem [0:1023];
    logic        st_en;
    logic [9:0]  st_addr;
    logic [15:0] st_data;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Store port: posedge write, so a same-edge fetch sees the old word.
    always @(posedge clk) begin
        if (st_en) mem[st_addr] <= st_data;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [9:0] pc);
        check_value({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check_value({tag, "_pc"}, 32'(inst_pc), 32'(pc));
        check_value({tag, "_data"}, 32'(inst_data), 32'({6'd0, pc} ^ 16'hA5A5));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_value("rst_valid", 32'(inst_valid), 32'd0);
        check_value("rst_addr", 32'(mem_addr), 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 10'd0;
        inst_ready = 1'b0;
        st_en = 1'b0;
        st_addr = 10'd0;
        st_data = 16'd0;
        #2;
        check_value("rst_data", 32'(inst_data), 32'd0);
        check_value("rst_pc", 32'(inst_pc), 32'd0);

        // 1: streaming after reset
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_head("stream", 10'(k));
        end

        // 2: back-pressure saturates the buffer, then drains without gaps
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check_value("full_addr", 32'(mem_addr), 32'd2);
        check_head("full_head", 10'd0);
        inst_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            check_head("drain", 10'(k));
        end

        // 3: redirect with two entries buffered
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        step();
        redirect_valid = 1'b0;
        check_value("redir_valid", 32'(inst_valid), 32'd0);
        check_value("redir_addr", 32'(mem_addr), 32'h200);
        step();
        check_head("redir_head", 10'h200);

        // 4: address wrap-around
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FF;
        step();
        redirect_valid = 1'b0;
        check_value("wrap_gap", 32'(inst_valid), 32'd0);
        step();
        check_head("wrap0", 10'h3FF);
        step();
        check_head("wrap1", 10'h000);
        step();
        check_head("wrap2", 10'h001);

        // 5: halt drains the buffer and freezes the pc
        inst_ready = 1'b0;
        step();
        check_head("pre_halt", 10'h001);
        halt = 1'b1;
        inst_ready = 1'b1;
        step();
        check_head("halt_d0", 10'h002);
        step();
        check_value("halt_empty", 32'(inst_valid), 32'd0);
        step();
        check_value("halt_empty2", 32'(inst_valid), 32'd0);
        check_value("halt_addr", 32'(mem_addr), 32'h003);
        halt = 1'b0;
        step();
        check_head("resume", 10'h003);

        // 6: asynchronous reset mid-stream with a full buffer
        inst_ready = 1'b0;
        step();
        check_value("pre_rst_addr", 32'(mem_addr), 32'h005);
        rst = 1'b1;
        #1;
        check_value("async_valid", 32'(inst_valid), 32'd0);
        check_value("async_addr", 32'(mem_addr), 32'd0);
        step();
        rst = 1'b0;
        inst_ready = 1'b1;
        step();
        check_head("post_rst", 10'h000);

        // Store to the word being fetched at the same edge
        st_en = 1'b1;
        st_addr = mem_addr;
        st_data = 16'hBEEF;
        step();
        st_en = 1'b0;
        check_head("collide_old", 10'h001);
        redirect_valid = 1'b1;
        redirect_pc = 10'h001;
        step();
        redirect_valid = 1'b0;
        step();
        check_value("refetch_pc", 32'(inst_pc), 32'h001);
        check_value("refetch_data", 32'(inst_data), 32'h0000BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
